core_seq_ctrl: RTL and testbench



---
 rtl/core_seq_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq_ctrl.sv
// ---------------------------------------------------------------------------
// core_seq_ctrl
//
// Multi-cycle sequencer for the RISC-V core. Each instruction walks through
// FETCH -> DECODE -> EXEC -> (MEM) -> WB. The block generates the enable
// strobes for the instruction register, ALU result register, data memory,
// register file and PC. Instruction and data memory handshakes are guarded
// by a wait counter that traps on timeout.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   run        in   permit a new fetch; only looked at in FETCH
//   opcode     in   instr[6:0] from the instruction register
//   memRW      in   from control_block: 00 none, 01 read, 10 write
//   regWEn     in   register-file write enable from control_block
//   imem_req   out  instruction fetch request
//   imem_ack   in   fetch data valid this cycle
//   ir_we      out  load instruction register
//   alu_en     out  capture ALU result register
//   dmem_req   out  data memory request
//   dmem_we    out  data memory write (qualified by dmem_req)
//   dmem_ack   in   data access complete this cycle
//   rf_we      out  register file write strobe
//   pc_we      out  PC update strobe
//   trap       out  sticky fault flag, cleared only by rst
//   trap_code  out  01 illegal opcode, 10 imem timeout, 11 dmem timeout
//   state      out  current state (debug)
//   instr_cnt  out  retired instruction count, wraps
// ---------------------------------------------------------------------------
module core_seq_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic [1:0]       memRW,
  input  logic             regWEn,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_we,
  output logic             alu_en,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic             pc_we,
  output logic             trap,
  output logic [1:0]       trap_code,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  state_t           r_state;
  logic [7:0]       r_wait_cnt;
  logic             r_trap;
  logic [1:0]       r_trap_code;
  logic [CNT_W-1:0] r_instr_cnt;

  state_t           w_state_next;
  logic [7:0]       w_wait_next;
  logic [7:0]       w_wait_inc;
  logic             w_trap_next;
  logic [1:0]       w_trap_code_next;
  logic             w_retire;

  assign w_wait_inc = r_wait_cnt + 8'd1;

  // State, wait counter, trap flag and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_wait_cnt  <= 8'd0;
      r_trap      <= 1'b0;
      r_trap_code <= 2'b00;
      r_instr_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_wait_cnt  <= w_wait_next;
      r_trap      <= w_trap_next;
      r_trap_code <= w_trap_code_next;
      if (w_retire) begin
        r_instr_cnt <= r_instr_cnt + CNT_W'(1);
      end
    end
  end

  // Next-state and strobe decode. Strobes are purely combinational from the
  // current state plus the live handshake inputs.
  always_comb begin
    w_state_next     = r_state;
    w_wait_next      = r_wait_cnt;
    w_trap_next      = r_trap;
    w_trap_code_next = r_trap_code;
    w_retire         = 1'b0;
    imem_req         = 1'b0;
    ir_we            = 1'b0;
    alu_en           = 1'b0;
    dmem_req         = 1'b0;
    dmem_we          = 1'b0;
    rf_we            = 1'b0;
    pc_we            = 1'b0;

    case (r_state)
      S_FETCH: begin
        if (run) begin
          imem_req = 1'b1;
          if (imem_ack) begin
            // Ack wins even on the cycle the counter would hit the limit.
            ir_we        = 1'b1;
            w_state_next = S_DECODE;
            w_wait_next  = 8'd0;
          end else if (w_wait_inc == TO_LIMIT) begin
            w_state_next     = S_TRAP;
            w_wait_next      = 8'd0;
            w_trap_next      = 1'b1;
            w_trap_code_next = 2'b10;
          end else begin
            w_wait_next = w_wait_inc;
          end
        end else begin
          w_wait_next = 8'd0;
        end
      end

      S_DECODE: begin
        if (opcode == OP_R || opcode == OP_I || opcode == OP_LOAD) begin
          w_state_next = S_EXEC;
        end else begin
          w_state_next     = S_TRAP;
          w_trap_next      = 1'b1;
          w_trap_code_next = 2'b01;
        end
      end

      S_EXEC: begin
        alu_en = 1'b1;
        case (memRW)
          2'b00:   w_state_next = S_WB;
          2'b01,
          2'b10:   w_state_next = S_MEM;
          default: begin
            w_state_next     = S_TRAP;
            w_trap_next      = 1'b1;
            w_trap_code_next = 2'b01;
          end
        endcase
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = memRW[1];
        if (dmem_ack) begin
          w_state_next = S_WB;
          w_wait_next  = 8'd0;
        end else if (w_wait_inc == TO_LIMIT) begin
          w_state_next     = S_TRAP;
          w_wait_next      = 8'd0;
          w_trap_next      = 1'b1;
          w_trap_code_next = 2'b11;
        end else begin
          w_wait_next = w_wait_inc;
        end
      end

      S_WB: begin
        rf_we        = regWEn;
        pc_we        = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end

      S_TRAP: begin
        // Parked until reset; all strobes stay low.
      end

      default: begin
        // Encodings 6 and 7 are not legal states; fault with code 00.
        w_state_next     = S_TRAP;
        w_wait_next      = 8'd0;
        w_trap_next      = 1'b1;
        w_trap_code_next = 2'b00;
      end
    endcase
  end

  assign trap      = r_trap;
  assign trap_code = r_trap_code;
  assign state     = r_state;
  assign instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_core_seq_ctrl.sv
module tb_core_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [6:0]  opcode;
  logic [1:0]  memRW;
  logic        regWEn;
  logic        imem_req;
  logic        imem_ack;
  logic        ir_we;
  logic        alu_en;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        rf_we;
  logic        pc_we;
  logic        trap;
  logic [1:0]  trap_code;
  logic [2:0]  state;
  logic [31:0] instr_cnt;

  int vectors     = 0;
  int miscompares = 0;

  core_seq_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .opcode    (opcode),
    .memRW     (memRW),
    .regWEn    (regWEn),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .ir_we     (ir_we),
    .alu_en    (alu_en),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_ack  (dmem_ack),
    .rf_we     (rf_we),
    .pc_we     (pc_we),
    .trap      (trap),
    .trap_code (trap_code),
    .state     (state),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational outputs after input changes, before checking.
  task automatic settle();
    #1;
  endtask

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  initial begin
    rst = 1'b1; run = 1'b0; opcode = OP_R; memRW = 2'b00; regWEn = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;

    // ---- reset state ----
    cyc(); cyc();
    settle();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_code", 32'(trap_code), 32'd0);
    chk("rst_cnt", instr_cnt, 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    rst = 1'b0;

    // ---- ALU instruction, zero-wait fetch: 4 cycles ----
    run = 1'b1; imem_ack = 1'b1; opcode = OP_R; memRW = 2'b00; regWEn = 1'b1;
    settle();
    chk("alu_c0_state", 32'(state), 32'd0);
    chk("alu_c0_imem_req", 32'(imem_req), 32'd1);
    chk("alu_c0_ir_we", 32'(ir_we), 32'd1);
    cyc();
    chk("alu_c1_state", 32'(state), 32'd1);
    chk("alu_c1_ir_we", 32'(ir_we), 32'd0);
    chk("alu_c1_imem_req", 32'(imem_req), 32'd0);
    cyc();
    chk("alu_c2_state", 32'(state), 32'd2);
    chk("alu_c2_alu_en", 32'(alu_en), 32'd1);
    chk("alu_c2_dmem_req", 32'(dmem_req), 32'd0);
    cyc();
    chk("alu_c3_state", 32'(state), 32'd4);
    chk("alu_c3_rf_we", 32'(rf_we), 32'd1);
    chk("alu_c3_pc_we", 32'(pc_we), 32'd1);
    chk("alu_c3_dmem_req", 32'(dmem_req), 32'd0);
    chk("alu_c3_cnt", instr_cnt, 32'd0);
    cyc();
    chk("alu_c4_state", 32'(state), 32'd0);
    chk("alu_c4_cnt", instr_cnt, 32'd1);

    // ---- load, dmem_ack 3 cycles after dmem_req: 8 cycles ----
    opcode = OP_LOAD; memRW = 2'b01; regWEn = 1'b1;
    settle();
    chk("ld_c0_ir_we", 32'(ir_we), 32'd1);
    cyc();
    chk("ld_c1_state", 32'(state), 32'd1);
    cyc();
    chk("ld_c2_alu_en", 32'(alu_en), 32'd1);
    cyc();
    for (int k = 0; k < 4; k++) begin
      dmem_ack = (k == 3);
      settle();
      chk("ld_mem_state", 32'(state), 32'd3);
      chk("ld_dmem_req", 32'(dmem_req), 32'd1);
      chk("ld_dmem_we", 32'(dmem_we), 32'd0);
      chk("ld_mem_rf_we", 32'(rf_we), 32'd0);
      cyc();
    end
    dmem_ack = 1'b0;
    settle();
    chk("ld_c7_state", 32'(state), 32'd4);
    chk("ld_c7_dmem_req", 32'(dmem_req), 32'd0);
    chk("ld_c7_rf_we", 32'(rf_we), 32'd1);
    chk("ld_c7_pc_we", 32'(pc_we), 32'd1);
    cyc();
    chk("ld_c8_state", 32'(state), 32'd0);
    chk("ld_c8_cnt", instr_cnt, 32'd2);

    // ---- illegal opcode -> TRAP code 01, held for 20 cycles ----
    opcode = OP_STORE; memRW = 2'b00;
    settle();
    chk("ill_c0_ir_we", 32'(ir_we), 32'd1);
    cyc();
    chk("ill_c1_state", 32'(state), 32'd1);
    chk("ill_c1_trap", 32'(trap), 32'd0);
    cyc();
    for (int k = 0; k < 20; k++) begin
      chk("ill_state", 32'(state), 32'd5);
      chk("ill_trap", 32'(trap), 32'd1);
      chk("ill_code", 32'(trap_code), 32'd1);
      chk("ill_rf_we", 32'(rf_we), 32'd0);
      chk("ill_pc_we", 32'(pc_we), 32'd0);
      chk("ill_imem_req", 32'(imem_req), 32'd0);
      cyc();
    end
    chk("ill_cnt", instr_cnt, 32'd2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    settle();
    chk("ill_rst_state", 32'(state), 32'd0);
    chk("ill_rst_trap", 32'(trap), 32'd0);
    chk("ill_rst_cnt", instr_cnt, 32'd0);

    // ---- imem timeout: 16 request cycles, then TRAP code 10 ----
    run = 1'b1; imem_ack = 1'b0; opcode = OP_R; memRW = 2'b00;
    settle();
    for (int k = 0; k < 16; k++) begin
      chk("ito_state", 32'(state), 32'd0);
      chk("ito_imem_req", 32'(imem_req), 32'd1);
      cyc();
    end
    chk("ito_trap_state", 32'(state), 32'd5);
    chk("ito_trap", 32'(trap), 32'd1);
    chk("ito_code", 32'(trap_code), 32'd2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;

    // ---- variant: ack on the 16th request cycle -> no trap ----
    for (int k = 0; k < 16; k++) begin
      imem_ack = (k == 15);
      settle();
      chk("iack16_state", 32'(state), 32'd0);
      chk("iack16_imem_req", 32'(imem_req), 32'd1);
      chk("iack16_ir_we", 32'(ir_we), 32'(k == 15));
      cyc();
    end
    imem_ack = 1'b0;
    settle();
    chk("iack16_decode", 32'(state), 32'd1);
    chk("iack16_trap", 32'(trap), 32'd0);
    cyc();
    // Drop run during EXEC: instruction still retires.
    run = 1'b0;
    settle();
    chk("drop_exec_state", 32'(state), 32'd2);
    cyc();
    chk("drop_wb_state", 32'(state), 32'd4);
    chk("drop_wb_pc_we", 32'(pc_we), 32'd1);
    cyc();
    imem_ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      settle();
      chk("idle_state", 32'(state), 32'd0);
      chk("idle_imem_req", 32'(imem_req), 32'd0);
      chk("idle_ir_we", 32'(ir_we), 32'd0);
      chk("idle_cnt", instr_cnt, 32'd1);
      cyc();
    end

    // ---- reset during MEM wait ----
    run = 1'b1; opcode = OP_LOAD; memRW = 2'b01; dmem_ack = 1'b0;
    cyc(); cyc(); cyc();
    settle();
    chk("mrst_in_mem", 32'(state), 32'd3);
    chk("mrst_dmem_req", 32'(dmem_req), 32'd1);
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; run = 1'b0;
    settle();
    chk("mrst_state", 32'(state), 32'd0);
    chk("mrst_dmem_req", 32'(dmem_req), 32'd0);
    chk("mrst_cnt", instr_cnt, 32'd0);
    chk("mrst_trap", 32'(trap), 32'd0);

    // ---- dmem timeout on a write: TRAP code 11 ----
    run = 1'b1; imem_ack = 1'b1; memRW = 2'b10; opcode = OP_LOAD;
    cyc(); cyc(); cyc();
    for (int k = 0; k < 16; k++) begin
      settle();
      chk("dto_state", 32'(state), 32'd3);
      chk("dto_dmem_req", 32'(dmem_req), 32'd1);
      chk("dto_dmem_we", 32'(dmem_we), 32'd1);
      cyc();
    end
    chk("dto_trap_state", 32'(state), 32'd5);
    chk("dto_trap", 32'(trap), 32'd1);
    chk("dto_code", 32'(trap_code), 32'd3);
    chk("dto_dmem_req_off", 32'(dmem_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
